gamma_dither_q8: RTL and testbench
==================================

Name: gamma_dither_q8

Overview:
Downstream of the gamma LUT stage. Takes the 12-bit per-channel gamma-corrected RGB stream with its video syncs and requantises each channel to 8 bits, with optional 1-D horizontal error-diffusion dither. Keeps vs/hs/de aligned with the pixel data. Reports a per-frame count of saturated pixels for ISP tuning.

Parameters:
DITHER_EN, 1, 1 = error-diffusion dither; 0 = round-half-up, no dither
CNT_W, 16, width of the clip counter and O_clip_cnt

Ports:
I_clk  input  1  pixel clock
I_rst  input  1  synchronous reset, active-high
I_vs  input  1  vertical sync, active-high
I_hs  input  1  horizontal sync, active-high
I_de  input  1  data enable, active-high
I_r  input  12  gamma-corrected red
I_g  input  12  gamma-corrected green
I_b  input  12  gamma-corrected blue
O_vs  output  1  I_vs delayed 2 cycles
O_hs  output  1  I_hs delayed 2 cycles
O_de  output  1  I_de delayed 2 cycles
O_r  output  8  requantised red
O_g  output  8  requantised green
O_b  output  8  requantised blue
O_clip_cnt  output  CNT_W  saturated-pixel count of the previous frame

Behaviour:
- One clock domain, I_clk. I_rst is synchronous and active-high. It clears every register: all outputs 0, error registers 0, clip accumulator 0.
- Stage 1 (S1): registers I_vs/hs/de/r/g/b into vs1/hs1/de1/r1/g1/b1.
- Stage 2 (S2): computes the outputs from the S1 data and registers them. Total latency is exactly 2 cycles for both data and syncs.
- Per channel, DITHER_EN=1:
  - 4-bit error register e.
  - sum = {1'b0, x1} + e, 13 bits.
  - If sum[12]=1: out = 255, e_next = 0, channel clipped.
  - Otherwise: out = sum[11:4], e_next = sum[3:0].
- Per channel, DITHER_EN=0:
  - sum = x1 + 8, 13 bits.
  - If sum[12]=1: out = 255, channel clipped.
  - Otherwise: out = sum[11:4].
  - The error registers stay 0.
- Error registers update only when de1=1.
- When de1=0: e forced to 0, so every line starts with zero error. O_r/g/b register 0.
- Pixel clip event: de1=1 and at least one channel clipped. Counted once per pixel.
- Clip accumulator:
  - Increments on each clip event and saturates at all-ones.
  - Frame boundary is the rising edge of vs1 (vs1=1 and the previous vs1=0).
  - On that edge: O_clip_cnt <= accumulator, and the accumulator is cleared.
- Simultaneous clip event and vs1 rising edge: O_clip_cnt latches the accumulator excluding this event; the accumulator restarts at 1.
- O_clip_cnt holds its value between edges. It is 0 until the first frame edge after reset.
- Reset asserted mid-line: outputs read 0 on the next cycle. After release, the first valid output appears 2 cycles after the first sampled I_de=1, with e=0.
- No backpressure; one pixel per cycle at full throughput.

Test Plan:
- Reset: drive random inputs with I_rst=1 for 4 cycles -> all outputs 0, O_clip_cnt=0. After release, O_de follows I_de with exactly 2-cycle delay.
- DITHER_EN=1, 30-pixel line at constant 12'd4086:
  - Outputs 255 every pixel; error sequence 6, 12, then clip (e=0), repeating.
  - 10 clip events; after the next vs rise, O_clip_cnt=10.
- DITHER_EN=1, constant 12'd24 on all channels -> O_r/g/b alternate 1, 2, 1, 2… starting with 1 on every line, because the error is reset when de drops.
- DITHER_EN=0, constant 12'd24 -> every output 2. Constant 12'd4092 -> output 255 and a clip counted per pixel. Constant 12'd4086 -> 255 with no clip.
- Clip event in the same cycle as a vs1 rising edge, with 5 prior clips -> O_clip_cnt=5 and the accumulator resumes at 1. The next frame edge, after 3 more clips, gives O_clip_cnt=4.
- Clip counter saturation: drive more than 65535 clip events in one frame (CNT_W=16) -> O_clip_cnt=16'hFFFF at the frame edge, with no wrap.

Source files
------------

// File: rtl/gamma_dither_q8.sv
// gamma_dither_q8: requantise 12-bit RGB to 8 bits with optional horizontal error-diffusion dither,
// two-cycle sync alignment and a per-frame saturated-pixel counter.
module gamma_dither_q8 #(
    parameter bit DITHER_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_vs,
    input  logic             I_hs,
    input  logic             I_de,
    input  logic [11:0]      I_r,
    input  logic [11:0]      I_g,
    input  logic [11:0]      I_b,
    output logic             O_vs,
    output logic             O_hs,
    output logic             O_de,
    output logic [7:0]       O_r,
    output logic [7:0]       O_g,
    output logic [7:0]       O_b,
    output logic [CNT_W-1:0] O_clip_cnt
);
    logic             vs1, hs1, de1, vs1_d;
    logic [2:0][11:0] pix1;
    logic [2:0][3:0]  err, err_nxt;
    logic [2:0][12:0] sum;
    logic [2:0][7:0]  q;
    logic [2:0]       clip;
    logic             ev, rise;
    logic [CNT_W-1:0] acc;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sum[i]     = {1'b0, pix1[i]} + (DITHER_EN ? {9'd0, err[i]} : 13'd8);
            clip[i]    = sum[i][12];
            q[i]       = clip[i] ? 8'hff : sum[i][11:4];
            err_nxt[i] = (DITHER_EN && de1 && !clip[i]) ? sum[i][3:0] : 4'd0;
        end
    end
    assign ev   = de1 && |clip;
    assign rise = vs1 && !vs1_d;
    // a clip coinciding with the frame edge belongs to the new frame
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            {vs1, hs1, de1, vs1_d} <= '0;
            pix1       <= '0;
            err        <= '0;
            acc        <= '0;
            {O_vs, O_hs, O_de} <= '0;
            {O_r, O_g, O_b}    <= '0;
            O_clip_cnt <= '0;
        end else begin
            {vs1, hs1, de1} <= {I_vs, I_hs, I_de};
            pix1  <= {I_r, I_g, I_b};
            vs1_d <= vs1;
            {O_vs, O_hs, O_de} <= {vs1, hs1, de1};
            err   <= err_nxt;
            O_r   <= de1 ? q[2] : 8'd0;
            O_g   <= de1 ? q[1] : 8'd0;
            O_b   <= de1 ? q[0] : 8'd0;
            if (rise) begin
                O_clip_cnt <= acc;
                acc        <= CNT_W'(ev);
            end else if (ev && acc != '1) begin
                acc <= acc + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gamma_dither_q8.sv
// tb_gamma_dither_q8: three configurations (dither, round, 4-bit counter) checked against
// an arithmetic reference model, plus directed corner-case sequences.
module tb_gamma_dither_q8;
    logic        clk = 1'b0;
    logic        rst, vs, hs, de;
    logic [11:0] r, g, b;
    logic [2:0]  o_vs, o_hs, o_de;
    logic [7:0]  o_r [3];
    logic [7:0]  o_g [3];
    logic [7:0]  o_b [3];
    logic [15:0] cnt_d, cnt_n;
    logic [3:0]  cnt_s;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    gamma_dither_q8 #(.DITHER_EN(1'b1), .CNT_W(16)) u_d (
        .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_hs(hs), .I_de(de), .I_r(r), .I_g(g), .I_b(b),
        .O_vs(o_vs[0]), .O_hs(o_hs[0]), .O_de(o_de[0]), .O_r(o_r[0]), .O_g(o_g[0]), .O_b(o_b[0]),
        .O_clip_cnt(cnt_d));
    gamma_dither_q8 #(.DITHER_EN(1'b0), .CNT_W(16)) u_n (
        .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_hs(hs), .I_de(de), .I_r(r), .I_g(g), .I_b(b),
        .O_vs(o_vs[1]), .O_hs(o_hs[1]), .O_de(o_de[1]), .O_r(o_r[1]), .O_g(o_g[1]), .O_b(o_b[1]),
        .O_clip_cnt(cnt_n));
    gamma_dither_q8 #(.DITHER_EN(1'b0), .CNT_W(4)) u_s (
        .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_hs(hs), .I_de(de), .I_r(r), .I_g(g), .I_b(b),
        .O_vs(o_vs[2]), .O_hs(o_hs[2]), .O_de(o_de[2]), .O_r(o_r[2]), .O_g(o_g[2]), .O_b(o_b[2]),
        .O_clip_cnt(cnt_s));

    typedef struct packed {
        logic vs, hs, de;
        logic [11:0] r, g, b;
    } pix_t;
    typedef struct {
        int x;
        int exp_n;
        int exp_d;
    } vec_t;

    // reference model state, one slot per instance
    int   dith [3] = '{1, 0, 0};
    int   cmax [3] = '{65535, 65535, 15};
    int   m_err [3][3];
    int   m_acc [3];
    int   m_cnt [3];
    int   ex_c [3][3];
    logic m_vs1, ex_vs, ex_hs, ex_de;
    pix_t p;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int d);
        return d == 0 ? 32'(cnt_d) : d == 1 ? 32'(cnt_n) : 32'(cnt_s);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0;
            m_cnt[d] = 0;
            for (int c = 0; c < 3; c++) begin
                m_err[d][c] = 0;
                ex_c[d][c] = 0;
            end
        end
        m_vs1 = 0; ex_vs = 0; ex_hs = 0; ex_de = 0;
        p = '0;
    endtask

    // processes the pixel held in the first pipeline stage
    task automatic model_step();
        int x [3];
        bit rs, ev;
        x[0] = p.r; x[1] = p.g; x[2] = p.b;
        rs = p.vs && !m_vs1;
        for (int d = 0; d < 3; d++) begin
            ev = 0;
            for (int c = 0; c < 3; c++) begin
                int t;
                t = x[c] + (dith[d] != 0 ? m_err[d][c] : 8);
                if (!p.de) begin
                    ex_c[d][c] = 0;
                    m_err[d][c] = 0;
                end else if (t >= 4096) begin
                    ex_c[d][c] = 255;
                    m_err[d][c] = 0;
                    ev = 1;
                end else begin
                    ex_c[d][c] = t / 16;
                    m_err[d][c] = dith[d] != 0 ? t % 16 : 0;
                end
            end
            if (rs) begin
                m_cnt[d] = m_acc[d];
                m_acc[d] = ev ? 1 : 0;
            end else if (ev && m_acc[d] < cmax[d]) begin
                m_acc[d]++;
            end
        end
        ex_vs = p.vs; ex_hs = p.hs; ex_de = p.de;
        m_vs1 = p.vs;
    endtask

    task automatic step(input logic s_rst, input logic s_vs, input logic s_hs, input logic s_de,
                        input logic [11:0] s_r, input logic [11:0] s_g, input logic [11:0] s_b);
        rst = s_rst; vs = s_vs; hs = s_hs; de = s_de; r = s_r; g = s_g; b = s_b;
        @(posedge clk);
        #1;
        if (s_rst) model_reset();
        else begin
            model_step();
            p = '{s_vs, s_hs, s_de, s_r, s_g, s_b};
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("vs[%0d]", d), 32'(o_vs[d]), 32'(ex_vs));
            check($sformatf("hs[%0d]", d), 32'(o_hs[d]), 32'(ex_hs));
            check($sformatf("de[%0d]", d), 32'(o_de[d]), 32'(ex_de));
            check($sformatf("r[%0d]", d), 32'(o_r[d]), ex_c[d][0]);
            check($sformatf("g[%0d]", d), 32'(o_g[d]), ex_c[d][1]);
            check($sformatf("b[%0d]", d), 32'(o_b[d]), ex_c[d][2]);
            check($sformatf("clip_cnt[%0d]", d), get_cnt(d), m_cnt[d]);
        end
    endtask

    task automatic pix(input logic s_vs, input logic s_de, input logic [11:0] x);
        step(1'b0, s_vs, 1'b0, s_de, x, x, x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 12'd0);
    endtask

    task automatic vs_pulse();
        pix(1'b1, 1'b0, 12'd0);
        pix(1'b0, 1'b0, 12'd0);
    endtask

    initial begin
        vec_t vt [11];
        vt[0]  = '{24, 2, 1};
        vt[1]  = '{4092, 255, 255};
        vt[2]  = '{4086, 255, 255};
        vt[3]  = '{0, 0, 0};
        vt[4]  = '{7, 0, 0};
        vt[5]  = '{8, 1, 0};
        vt[6]  = '{4087, 255, 255};
        vt[7]  = '{4088, 255, 255};
        vt[8]  = '{15, 1, 0};
        vt[9]  = '{16, 1, 1};
        vt[10] = '{2047, 128, 127};
        model_reset();

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                 12'($urandom), 12'($urandom), 12'($urandom));
            check("rst_de", 32'(o_de[0]), 0);
            check("rst_r", 32'(o_r[0]), 0);
            check("rst_cnt", 32'(cnt_d), 0);
        end
        pix(1'b0, 1'b1, 12'd100);
        check("de_lat1", 32'(o_de[0]), 0);
        pix(1'b0, 1'b1, 12'd100);
        check("de_lat2", 32'(o_de[0]), 1);
        idle(2);

        for (int i = 0; i < 11; i++) begin
            pix(1'b0, 1'b1, 12'(vt[i].x));
            pix(1'b0, 1'b0, 12'd0);
            check($sformatf("vec%0d_round", i), 32'(o_g[1]), vt[i].exp_n);
            check($sformatf("vec%0d_dither", i), 32'(o_g[0]), vt[i].exp_d);
        end

        vs_pulse();
        idle(1);
        for (int i = 0; i < 31; i++) begin
            pix(1'b0, i < 30, 12'd4086);
            if (i > 0) check("line4086_out", 32'(o_r[0]), 255);
        end
        idle(1);
        vs_pulse();
        check("line4086_clips_dither", 32'(cnt_d), 10);
        check("line4086_clips_round", 32'(cnt_n), 0);

        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 7; i++) begin
                pix(1'b0, i < 6, 12'd24);
                if (i > 0) begin
                    check("d24_dither", 32'(o_g[0]), (i - 1) % 2 ? 2 : 1);
                    check("d24_round", 32'(o_b[1]), 2);
                end
            end
            idle(2);
        end

        vs_pulse();
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, 12'd4092);
        pix(1'b1, 1'b1, 12'd4092);
        pix(1'b0, 1'b1, 12'd4092);
        check("edge_clip_prev", 32'(cnt_n), 5);
        pix(1'b0, 1'b1, 12'd4092);
        pix(1'b0, 1'b1, 12'd4092);
        pix(1'b0, 1'b0, 12'd0);
        vs_pulse();
        check("edge_clip_next", 32'(cnt_n), 4);

        for (int i = 0; i < 20; i++) pix(1'b0, 1'b1, 12'd4092);
        idle(1);
        vs_pulse();
        check("sat_cnt", 32'(cnt_s), 15);
        check("sat_cnt_wide", 32'(cnt_n), 20);

        for (int i = 0; i < 3000; i++) begin
            logic [11:0] c [3];
            for (int k = 0; k < 3; k++)
                c[k] = $urandom_range(0, 3) == 0 ? 12'($urandom_range(4080, 4095)) : 12'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, c[0], c[1], c[2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
